stage2_ctrl: RTL and testbench



---
 rtl/stage2_pkg.sv | 27 ++
 rtl/stage2_ctrl_rr_arbiter.sv | 32 +++
 rtl/stage2_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stage2_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage2_pkg.sv
// Shared definitions for the stage-2 sequencer: FSM encoding, operand field
// widths and the LFSR seed/step helpers.
package stage2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int EFFORT_W = 7;
  localparam int HARD_W   = 5;
  localparam int RAND_W   = 5;
  localparam int BONUS_W  = 2;

  localparam logic [RAND_W-1:0] SEED_DEFAULT = 5'h1F;

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  function automatic logic [RAND_W-1:0] fix_seed(input logic [RAND_W-1:0] s);
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

  function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

endpackage

// File: rtl/stage2_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// last_id_i+1, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_id_i,
  output logic            valid_o,
  output logic [IDW-1:0]  id_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last_id_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/stage2_ctrl.sv
// Shares one combinational stage2 evaluator among NREQ requesters (IDLE/EVAL/RESP).
// Optional pass counter enabled by defining STAGE2_CTRL_STATS_EN.
module stage2_ctrl
  import stage2_pkg::*;
#(
  parameter int                NREQ      = 4,
  parameter int                IDW       = $clog2(NREQ),
  parameter logic [RAND_W-1:0] LFSR_SEED = SEED_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          pass1_i,
  input  logic [BONUS_W*NREQ-1:0]  bonus1_i,
  input  logic [EFFORT_W*NREQ-1:0] effort_i,
  input  logic [HARD_W*NREQ-1:0]   hard_i,
  output logic [NREQ-1:0]          ack,
  output logic                     pass2_o,
  output logic [BONUS_W-1:0]       bonus2_o,
  output logic [IDW-1:0]           resp_id,
  output logic                     busy,
  output logic                     s2_pass1,
  output logic [BONUS_W-1:0]       s2_bonus1,
  output logic [EFFORT_W-1:0]      s2_effort,
  output logic [HARD_W-1:0]        s2_hard,
  output logic [RAND_W-1:0]        s2_random2,
  input  logic                     s2_pass2,
  input  logic [BONUS_W-1:0]       s2_bonus2,
  output state_t                   dbg_state_o
`ifdef STAGE2_CTRL_STATS_EN
  ,
  output logic [15:0]              pass_cnt
`endif
);

  localparam logic [RAND_W-1:0] SEED_EFF = fix_seed(LFSR_SEED);

  // Handshake: a requester holds req until it sees its one-cycle ack pulse and
  // drops req at the edge closing that cycle; operands are latched at grant, so
  // req or operand changes after the grant never affect the running transaction.

  state_t state_q, state_d;

  logic                gnt_valid;
  logic [IDW-1:0]      gnt_id;
  logic                sel_pass1;
  logic [BONUS_W-1:0]  sel_bonus1;
  logic [EFFORT_W-1:0] sel_effort;
  logic [HARD_W-1:0]   sel_hard;

  logic [IDW-1:0]      id_q, last_id_q, resp_id_q;
  logic [RAND_W-1:0]   lfsr_q;
  logic [NREQ-1:0]     ack_q;
  logic                pass2_q;
  logic [BONUS_W-1:0]  bonus2_q;
  logic                op_pass1_q;
  logic [BONUS_W-1:0]  op_bonus1_q;
  logic [EFFORT_W-1:0] op_effort_q;
  logic [HARD_W-1:0]   op_hard_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (req),
    .last_id_i (last_id_q),
    .valid_o   (gnt_valid),
    .id_o      (gnt_id)
  );

  always_comb begin
    sel_pass1  = 1'b0;
    sel_bonus1 = '0;
    sel_effort = '0;
    sel_hard   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_pass1  = pass1_i[k];
        sel_bonus1 = bonus1_i[k*BONUS_W +: BONUS_W];
        sel_effort = effort_i[k*EFFORT_W +: EFFORT_W];
        sel_hard   = hard_i[k*HARD_W +: HARD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == EVAL) || (state_q == RESP);
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q        <= '0;
      last_id_q   <= IDW'(NREQ-1);
      resp_id_q   <= '0;
      lfsr_q      <= SEED_EFF;
      ack_q       <= '0;
      pass2_q     <= 1'b0;
      bonus2_q    <= '0;
      op_pass1_q  <= 1'b0;
      op_bonus1_q <= '0;
      op_effort_q <= '0;
      op_hard_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            id_q        <= gnt_id;
            op_pass1_q  <= sel_pass1;
            op_bonus1_q <= sel_bonus1;
            op_effort_q <= sel_effort;
            op_hard_q   <= sel_hard;
          end
        end
        EVAL: begin
          pass2_q   <= s2_pass2;
          bonus2_q  <= s2_bonus2;
          resp_id_q <= id_q;
          ack_q     <= {{(NREQ-1){1'b0}}, 1'b1} << id_q;
        end
        RESP: begin
          ack_q     <= '0;
          last_id_q <= id_q;
          lfsr_q    <= lfsr_next(lfsr_q);
        end
        default: ;
      endcase
    end
  end

`ifdef STAGE2_CTRL_STATS_EN
  logic [15:0] pass_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pass_cnt_q <= '0;
    else if (state_q == RESP && pass2_q && pass_cnt_q != 16'hFFFF)
      pass_cnt_q <= pass_cnt_q + 16'd1;
  end

  assign pass_cnt = pass_cnt_q;
`endif

  assign ack        = ack_q;
  assign pass2_o    = pass2_q;
  assign bonus2_o   = bonus2_q;
  assign resp_id    = resp_id_q;
  assign s2_pass1   = op_pass1_q;
  assign s2_bonus1  = op_bonus1_q;
  assign s2_effort  = op_effort_q;
  assign s2_hard    = op_hard_q;
  assign s2_random2 = lfsr_q;

endmodule

// File: tb/tb_stage2_ctrl.sv
// Directed + randomized bench for stage2_ctrl with a behavioural stage2 stand-in
// and a transaction-level reference model.
module tb_stage2_ctrl;
  import stage2_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]   req = '0;
  logic              p1 [NREQ];
  logic [1:0]        b1 [NREQ];
  logic [6:0]        ef [NREQ];
  logic [4:0]        hd [NREQ];
  logic [NREQ-1:0]   pass1_i;
  logic [2*NREQ-1:0] bonus1_i;
  logic [7*NREQ-1:0] effort_i;
  logic [5*NREQ-1:0] hard_i;

  logic [NREQ-1:0] ack;
  logic            pass2_o;
  logic [1:0]      bonus2_o;
  logic [IDW-1:0]  resp_id;
  logic            busy;
  logic            s2_pass1;
  logic [1:0]      s2_bonus1;
  logic [6:0]      s2_effort;
  logic [4:0]      s2_hard;
  logic [4:0]      s2_random2;
  logic            s2_pass2;
  logic [1:0]      s2_bonus2;
  state_t          dbg_state;
`ifdef STAGE2_CTRL_STATS_EN
  logic [15:0]     pass_cnt;
`endif

  stage2_ctrl #(.NREQ(NREQ), .IDW(IDW), .LFSR_SEED(5'h1F)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .pass1_i     (pass1_i),
    .bonus1_i    (bonus1_i),
    .effort_i    (effort_i),
    .hard_i      (hard_i),
    .ack         (ack),
    .pass2_o     (pass2_o),
    .bonus2_o    (bonus2_o),
    .resp_id     (resp_id),
    .busy        (busy),
    .s2_pass1    (s2_pass1),
    .s2_bonus1   (s2_bonus1),
    .s2_effort   (s2_effort),
    .s2_hard     (s2_hard),
    .s2_random2  (s2_random2),
    .s2_pass2    (s2_pass2),
    .s2_bonus2   (s2_bonus2),
    .dbg_state_o (dbg_state)
`ifdef STAGE2_CTRL_STATS_EN
    ,
    .pass_cnt    (pass_cnt)
`endif
  );

  // ---------------- clock / stage2 stand-in ----------------
  always #5 clk = ~clk;

  // stage2 stand-in: pass when pass1 and effort >= 4*hard; bonus = bonus1 + random2[0], capped at 3
  logic [2:0] s2_sum;
  assign s2_pass2  = s2_pass1 && (s2_effort >= {s2_hard, 2'b00});
  assign s2_sum    = {1'b0, s2_bonus1} + {2'b00, s2_random2[0]};
  assign s2_bonus2 = s2_sum[2] ? 2'd3 : s2_sum[1:0];

  always_comb begin
    pass1_i  = '0;
    bonus1_i = '0;
    effort_i = '0;
    hard_i   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pass1_i[k]        = p1[k];
      bonus1_i[2*k +: 2] = b1[k];
      effort_i[7*k +: 7] = ef[k];
      hard_i[5*k +: 5]   = hd[k];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_last;
  int exp_lfsr;
  int exp_cnt;
  logic [4:0] exp_q[$];
  logic [4:0] last_rand;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (last + i) % NREQ;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic int model_lfsr(input int x);
    return ((x * 2) & 31) | (((x >> 4) ^ (x >> 2)) & 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int k, input logic p, input logic [1:0] b,
                            input logic [6:0] e, input logic [4:0] h);
    p1[k] = p; b1[k] = b; ef[k] = e; hd[k] = h;
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < NREQ; k++)
      set_fields(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_last = NREQ - 1;
    exp_lfsr = 5'h1F;
    exp_cnt  = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Precondition: at a negedge with the DUT in IDLE and req != 0.
  task automatic step_txn(input bit scramble, output int won);
    int w, pw, bw;
    logic [4:0] e;
    logic op_p;
    logic [1:0] op_b;
    logic [6:0] op_e;
    logic [4:0] op_h;
    w    = model_pick(req, exp_last);
    op_p = p1[w]; op_b = b1[w]; op_e = ef[w]; op_h = hd[w];
    pw   = (op_p && (int'(op_e) >= 4 * int'(op_h))) ? 1 : 0;
    bw   = int'(op_b) + (exp_lfsr & 1);
    if (bw > 3) bw = 3;
    exp_q.push_back({2'(w), 1'(pw), 2'(bw)});
    @(negedge clk);
    check("eval_busy", 32'(busy), 32'd1);
    check("eval_ack", 32'(ack), 32'd0);
    check("eval_pass1", 32'(s2_pass1), 32'(op_p));
    check("eval_bonus1", 32'(s2_bonus1), 32'(op_b));
    check("eval_effort", 32'(s2_effort), 32'(op_e));
    check("eval_hard", 32'(s2_hard), 32'(op_h));
    check("eval_random2", 32'(s2_random2), 32'(exp_lfsr));
    last_rand = s2_random2;
    if (scramble) begin
      randomize_fields();
      req = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check("resp_ack", 32'(ack), 32'(1) << e[4:3]);
    check("resp_id", 32'(resp_id), 32'(e[4:3]));
    check("resp_pass2", 32'(pass2_o), 32'(e[2]));
    check("resp_bonus2", 32'(bonus2_o), 32'(e[1:0]));
    check("resp_busy", 32'(busy), 32'd1);
    exp_last = w;
    exp_lfsr = model_lfsr(exp_lfsr);
    exp_cnt  = exp_cnt + pw;
    @(negedge clk);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_random2", 32'(s2_random2), 32'(exp_lfsr));
    check("hold_pass2", 32'(pass2_o), 32'(e[2]));
    check("hold_bonus2", 32'(bonus2_o), 32'(e[1:0]));
`ifdef STAGE2_CTRL_STATS_EN
    check("pass_cnt", 32'(pass_cnt), 32'(exp_cnt));
`endif
    won = w;
  endtask

  // ---------------- directed sequence ----------------
  int won;
  int order [5] = '{0, 1, 2, 3, 0};
  logic [4:0] lfsr_ref [3] = '{5'h1F, 5'h1E, 5'h1C};
  logic [1:0] pass_pat [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

  initial begin
    for (int k = 0; k < NREQ; k++) set_fields(k, 1'b0, 2'd0, 7'd0, 5'd0);

    // reset values
    do_reset();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pass2", 32'(pass2_o), 32'd0);
    check("reset_bonus2", 32'(bonus2_o), 32'd0);
    check("reset_resp_id", 32'(resp_id), 32'd0);
    check("reset_random2", 32'(s2_random2), 32'h1F);
    check("reset_s2_effort", 32'(s2_effort), 32'd0);
`ifdef STAGE2_CTRL_STATS_EN
    check("reset_pass_cnt", 32'(pass_cnt), 32'd0);
`endif

    // single request
    set_fields(0, 1'b1, 2'd2, 7'd100, 5'd10);
    req = 4'b0001;
    step_txn(1'b0, won);
    check("single_pass2", 32'(pass2_o), 32'd1);
    check("single_bonus2", 32'(bonus2_o), 32'd3);
    check("single_id", 32'(resp_id), 32'd0);
    check("single_random2", 32'(last_rand), 32'h1F);

    // idle with no request
    req = '0;
    repeat (2) begin
      @(negedge clk);
      check("noreq_busy", 32'(busy), 32'd0);
      check("noreq_ack", 32'(ack), 32'd0);
    end

    // fairness and LFSR sequence
    do_reset();
    randomize_fields();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step_txn(1'b0, won);
      check("fair_order", 32'(resp_id), 32'(order[i]));
      if (i < 3) check("lfsr_seq", 32'(last_rand), 32'(lfsr_ref[i]));
    end

    // randomized traffic with operand/req churn after grant
    for (int i = 0; i < 40; i++) begin
      if (req == '0) req = 4'($urandom_range(1, 15));
      step_txn(1'b1, won);
    end

    // reset during EVAL aborts the transaction
    req = 4'b0100;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req = '0;
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_state_busy", 32'(busy), 32'd0);
    check("abort_random2", 32'(s2_random2), 32'h1F);
    @(negedge clk);
    check("abort_no_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    exp_last = NREQ - 1;
    exp_lfsr = 5'h1F;
    exp_cnt  = 0;
    exp_q.delete();
    @(negedge clk);
    check("abort_idle_ack", 32'(ack), 32'd0);
    req = 4'b0101;
    step_txn(1'b0, won);
    check("abort_next_id", 32'(resp_id), 32'd0);
    check("abort_next_random2", 32'(last_rand), 32'h1F);

    // stats: three passing, two failing
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_fields(0, pass_pat[i][0], 2'd0, 7'd100, 5'd10);
      step_txn(1'b0, won);
    end
`ifdef STAGE2_CTRL_STATS_EN
    check("stats_pass_cnt", 32'(pass_cnt), 32'd3);
`endif
    check("stats_last_pass2", 32'(pass2_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
